// File: rtl/comparador_serie_d_i_pkg.sv
// Shared definitions for the bit-serial LSB-first magnitude comparator:
// FSM state encoding and the bit-counter width derivation.
package comparador_serie_d_i_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Counter must hold 0..WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/comparador_serie_d_i_celda.sv
// Typical comparator cell: propagates the chain state x through one bit pair.
// a<b at this bit forces 1, a>b forces 0, equal bits pass x unchanged.
module Celda_tipica_d_i (
  input  logic a_p,
  input  logic b_p,
  input  logic x_p,
  output logic p_x
);

  assign p_x = (~a_p & x_p) | (b_p & x_p) | (~a_p & b_p);

endmodule

// File: rtl/comparador_serie_d_i.sv
// Bit-serial, LSB-first unsigned magnitude comparator.
// Latches A, B and the initial chain state, then runs one comparator cell per
// clock, feeding its output back as the next state. x_in=0 yields A<B,
// x_in=1 yields A<=B.
// Optional macro COMPARADOR_SERIE_EQ_EN adds the registered equality flag eq_out.
module comparador_serie_d_i
  import comparador_serie_d_i_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             x_in,
  output logic             busy,
  output logic             done,
  output logic             p_out
`ifdef COMPARADOR_SERIE_EQ_EN
  ,
  output logic             eq_out
`endif
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             x_reg;
  logic [CNT_W-1:0] cnt;
  logic             x_next;
`ifdef COMPARADOR_SERIE_EQ_EN
  logic             eq_reg;
  logic             bit_eq;

  assign bit_eq = ~(a_sr[0] ^ b_sr[0]);
`endif

  Celda_tipica_d_i u_celda (
    .a_p (a_sr[0]),
    .b_p (b_sr[0]),
    .x_p (x_reg),
    .p_x (x_next)
  );

  // Control FSM and datapath: load, shift one bit per clock, register result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      p_out  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      x_reg  <= 1'b0;
      cnt    <= '0;
`ifdef COMPARADOR_SERIE_EQ_EN
      eq_reg <= 1'b0;
      eq_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            x_reg  <= x_in;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef COMPARADOR_SERIE_EQ_EN
            eq_reg <= 1'b1;
`endif
          end
        end
        SHIFT: begin
          x_reg <= x_next;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + CNT_W'(1);
`ifdef COMPARADOR_SERIE_EQ_EN
          eq_reg <= eq_reg & bit_eq;
`endif
          if (cnt == LAST) begin
            p_out <= x_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef COMPARADOR_SERIE_EQ_EN
            eq_out <= eq_reg & bit_eq;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
